ndindex_scheduler: RTL and testbench
====================================

# ndindex_scheduler

Synchronous sequencer that walks a 3-dimensional index space (dimension 0 fastest) and emits one index tuple per beat on a valid/ready stream. It replaces the free-running ripple chain of mod-N counters with a single-clock-domain controller that has run-time extents, start/abort control, backpressure and a completion pulse. It sits between the job control logic and any datapath consuming `ndindex_0..2`.

## Interface
- `WIDTH`, 32, width of each extent and index
- `clk`  in  1  sole clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin a walk; sampled only in IDLE
- `abort`  in  1  terminate a walk in RUN; no `done`
- `ext_0`, `ext_1`, `ext_2`  in  WIDTH each  unsigned extents per dimension; latched on accepted `start`
- `out_ready`  in  1  consumer accepts the current beat
- `out_valid`  out  1  index tuple valid
- `ndindex_0`, `ndindex_1`, `ndindex_2`  out  WIDTH each  current index tuple
- `last`  out  1  current beat is the final tuple, qualified by `out_valid`
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse after normal completion

## Operation
- States: IDLE, RUN. Reset (`rst_n`=0 at an edge) forces IDLE, all outputs 0, latched extents 0, including mid-walk.
- IDLE with `start`=1:
  - All extents nonzero: latch extents, clear indices, go to RUN.
  - Any extent 0: stay IDLE, pulse `done` next cycle, emit no beats.
- RUN:
  - `out_valid`=1, `busy`=1.
  - A handshake (`out_valid`&`out_ready`) advances the tuple. Increment `ndindex_0`; at `ext_0`-1 wrap to 0 and carry into `ndindex_1`; likewise `ndindex_1` into `ndindex_2`.
  - `last`=1 when all three indices equal their extent-1.
  - Handshake with `last`=1: go to IDLE and pulse `done` on the next cycle.
- Without a handshake, indices and `last` hold stable (AXI-stream rule). `out_valid` never drops without a handshake, except on `abort` or reset.
- `abort` in RUN: go to IDLE next cycle, `out_valid`=0, no `done`. Abort together with a handshake: the beat counts as consumed, abort wins, no `done` even if `last`.
- `start` is ignored in RUN. `abort` is ignored in IDLE.
- `start` in the cycle `done` is high is accepted, because the block is already in IDLE.
- Arithmetic is unsigned WIDTH-bit. The comparison is index == ext-1. Extent 2^WIDTH-1 is legal. The index never exceeds ext-1.
- Extent inputs may change freely during RUN; only the latched copies are used.

## Timing
- `start` accepted at edge t: `busy`=1, `out_valid`=1 and tuple (0,0,0) visible after edge t, i.e. in cycle t+1.
- Throughput is one beat per cycle while `out_ready`=1. The total is ext_0·ext_1·ext_2 beats.
- Final handshake at edge t: in cycle t+1, `out_valid`=0, `busy`=0 and `done`=1 for exactly one cycle.
- Zero-extent start at edge t: `done`=1 in cycle t+1 only; `busy` stays 0.
- Minimum restart gap is 0 idle cycles after `done`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `NDSCHED_LINEAR_EN` defined:
  - Adds output `lin_index` (WIDTH), the flattened offset i0 + ext_0·(i1 + ext_1·i2).
  - It is maintained incrementally: cleared on start, +1 per handshake, no multiplier.
  - It is aligned with the tuple and reset to 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Normal walk: extents (2,3,1), `out_ready`=1. Expect 6 beats (0,0,0),(1,0,0),(0,1,0),(1,1,0),(0,2,0),(1,2,0), `last` on the 6th only, `done` one cycle after, `busy` low. With the macro, `lin_index` reads 0..5.
- Backpressure: extents (3,2,2), `out_ready` toggled pseudo-randomly. Expect tuples stable while stalled, exactly 12 accepted beats in order, one `done`.
- Zero extent: start with (4,0,5). Expect no `out_valid`, `done`=1 for one cycle in the next cycle, `busy`=0 throughout.
- Abort: extents (4,4,4), assert `abort` after 10 handshakes with `out_ready`=1. Expect 11 beats consumed (abort cycle included), IDLE next cycle, no `done`. A following start begins again at (0,0,0).
- Control corners: `start` pulses during RUN are ignored, and the walk is unchanged. `start` coincident with `done` launches the next walk immediately.
- Reset mid-walk: drop `rst_n` for one edge after 5 beats. Expect all outputs 0 next cycle, IDLE, no `done`.

Source files
------------

// File: rtl/ndindex_scheduler.sv
// ndindex_scheduler: 3-D index walker on a valid/ready stream; define NDSCHED_LINEAR_EN to add the lin_index flattened offset
module ndindex_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] ext_0,
  input  logic [WIDTH-1:0] ext_1,
  input  logic [WIDTH-1:0] ext_2,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] ndindex_0,
  output logic [WIDTH-1:0] ndindex_1,
  output logic [WIDTH-1:0] ndindex_2,
  output logic             last,
  output logic             busy,
`ifdef NDSCHED_LINEAR_EN
  output logic [WIDTH-1:0] lin_index,
`endif
  output logic             done
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state;
  logic [WIDTH-1:0] e0, e1, e2, n0, n1, n2;
  logic             hs, nz, w0, w1, nlast, first_last, accept;
  always_comb begin
    hs         = (state == RUN) && out_ready;
    nz         = (|ext_0) && (|ext_1) && (|ext_2);
    accept     = (state == IDLE) && start && nz;
    first_last = (ext_0 == WIDTH'(1)) && (ext_1 == WIDTH'(1)) && (ext_2 == WIDTH'(1));
    w0         = ndindex_0 == e0 - WIDTH'(1);
    w1         = ndindex_1 == e1 - WIDTH'(1);
    n0         = w0 ? '0 : ndindex_0 + WIDTH'(1);
    n1         = w0 ? (w1 ? '0 : ndindex_1 + WIDTH'(1)) : ndindex_1;
    n2         = (w0 && w1) ? ndindex_2 + WIDTH'(1) : ndindex_2;
    nlast      = (n0 == e0 - WIDTH'(1)) && (n1 == e1 - WIDTH'(1)) && (n2 == e2 - WIDTH'(1));
  end
  assign out_valid = state == RUN;
  assign busy      = state == RUN;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      e0        <= '0;
      e1        <= '0;
      e2        <= '0;
      ndindex_0 <= '0;
      ndindex_1 <= '0;
      ndindex_2 <= '0;
      last      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          state     <= RUN;
          e0        <= ext_0;
          e1        <= ext_1;
          e2        <= ext_2;
          ndindex_0 <= '0;
          ndindex_1 <= '0;
          ndindex_2 <= '0;
          last      <= first_last;
        end else if (start) begin
          done <= 1'b1;
        end
      end else if (abort) begin
        state <= IDLE;
        last  <= 1'b0;
      end else if (hs) begin
        if (last) begin
          state <= IDLE;
          last  <= 1'b0;
          done  <= 1'b1;
        end else begin
          ndindex_0 <= n0;
          ndindex_1 <= n1;
          ndindex_2 <= n2;
          last      <= nlast;
        end
      end
    end
  end
`ifdef NDSCHED_LINEAR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) lin_index <= '0;
    else if (accept) lin_index <= '0;
    else if (hs && !abort && !last) lin_index <= lin_index + WIDTH'(1);
  end
`endif
endmodule

// File: tb/tb_ndindex_scheduler.sv
// tb_ndindex_scheduler: table-driven walks plus directed corner sequences for ndindex_scheduler
module tb_ndindex_scheduler;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [W-1:0] ext_0 = '0, ext_1 = '0, ext_2 = '0;
  logic out_valid, last, busy, done;
  logic [W-1:0] ndindex_0, ndindex_1, ndindex_2;
`ifdef NDSCHED_LINEAR_EN
  logic [W-1:0] lin_index;
`endif
  int checks = 0, errors = 0;

  ndindex_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ext_0(ext_0), .ext_1(ext_1), .ext_2(ext_2), .out_ready(out_ready),
    .out_valid(out_valid), .ndindex_0(ndindex_0), .ndindex_1(ndindex_1), .ndindex_2(ndindex_2),
    .last(last), .busy(busy),
`ifdef NDSCHED_LINEAR_EN
    .lin_index(lin_index),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e0, e1, e2;
    bit bp, noise;
    int beats;
  } walk_t;
  walk_t tbl[5];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] tup(input int a, input int b, input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  task automatic walk(input int e0, input int e1, input int e2, input bit bp, input bit noise, output int beats);
    int k = 0;
    int cyc = 0;
    int tot = e0 * e1 * e2;
    bit r;
    ext_0 = W'(e0); ext_1 = W'(e1); ext_2 = W'(e2);
    start = 1'b1; abort = 1'b0;
    step();
    start = 1'b0;
    while (k < tot && cyc < 400) begin
      chk("valid", {95'd0, out_valid}, 96'd1);
      chk("busy", {95'd0, busy}, 96'd1);
      chk("tuple", {ndindex_2, ndindex_1, ndindex_0}, tup(k % e0, (k / e0) % e1, k / (e0 * e1)));
      chk("last", {95'd0, last}, {95'd0, k == tot - 1});
`ifdef NDSCHED_LINEAR_EN
      chk("lin_index", {64'd0, lin_index}, 96'(k));
`endif
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        ext_0 = $urandom; ext_1 = $urandom; ext_2 = $urandom;
      end
      step();
      cyc++;
      if (r) k++;
    end
    beats = k;
    start = 1'b0; out_ready = 1'b0;
    chk("end_valid", {95'd0, out_valid}, 96'd0);
    chk("end_busy", {95'd0, busy}, 96'd0);
    chk("done_pulse", {95'd0, done}, 96'd1);
  endtask

  initial begin
    int b;
    tbl[0] = '{2, 3, 1, 1'b0, 1'b0, 6};
    tbl[1] = '{3, 2, 2, 1'b1, 1'b0, 12};
    tbl[2] = '{1, 1, 1, 1'b0, 1'b0, 1};
    tbl[3] = '{5, 1, 3, 1'b1, 1'b1, 15};
    tbl[4] = '{1, 4, 2, 1'b0, 1'b1, 8};

    step(); step();
    chk("rst_valid", {95'd0, out_valid}, 96'd0);
    chk("rst_busy", {95'd0, busy}, 96'd0);
    chk("rst_done", {95'd0, done}, 96'd0);
    chk("rst_last", {95'd0, last}, 96'd0);
    chk("rst_tuple", {ndindex_2, ndindex_1, ndindex_0}, 96'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      walk(tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].bp, tbl[i].noise, b);
      chk("beat_count", 96'(b), 96'(tbl[i].beats));
      step();
      chk("done_once", {95'd0, done}, 96'd0);
    end

    walk(2, 1, 1, 1'b0, 1'b0, b);
    ext_0 = 1; ext_1 = 2; ext_2 = 1; start = 1'b1;
    step();
    start = 1'b0;
    chk("chain_valid", {95'd0, out_valid}, 96'd1);
    chk("chain_done", {95'd0, done}, 96'd0);
    chk("chain_tuple", {ndindex_2, ndindex_1, ndindex_0}, 96'd0);
    chk("chain_last0", {95'd0, last}, 96'd0);
    out_ready = 1'b1;
    step();
    chk("chain_tuple1", {ndindex_2, ndindex_1, ndindex_0}, tup(0, 1, 0));
    chk("chain_last1", {95'd0, last}, 96'd1);
    step();
    out_ready = 1'b0;
    chk("chain_end_done", {95'd0, done}, 96'd1);
    chk("chain_end_valid", {95'd0, out_valid}, 96'd0);
    step();

    ext_0 = 4; ext_1 = 0; ext_2 = 5; start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_valid", {95'd0, out_valid}, 96'd0);
    chk("zero_busy", {95'd0, busy}, 96'd0);
    chk("zero_done", {95'd0, done}, 96'd1);
    step();
    chk("zero_done_off", {95'd0, done}, 96'd0);
    chk("zero_valid2", {95'd0, out_valid}, 96'd0);

    ext_0 = 4; ext_1 = 4; ext_2 = 4; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("abort_tuple", {ndindex_2, ndindex_1, ndindex_0}, tup(2, 2, 0));
    chk("abort_pre_valid", {95'd0, out_valid}, 96'd1);
    abort = 1'b1;
    step();
    abort = 1'b0; out_ready = 1'b0;
    chk("abort_valid", {95'd0, out_valid}, 96'd0);
    chk("abort_busy", {95'd0, busy}, 96'd0);
    chk("abort_done", {95'd0, done}, 96'd0);
    step();
    chk("abort_done2", {95'd0, done}, 96'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_valid", {95'd0, out_valid}, 96'd1);
    chk("restart_tuple", {ndindex_2, ndindex_1, ndindex_0}, 96'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    ext_0 = 32'hFFFF_FFFF; ext_1 = 1; ext_2 = 1; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("wide_last0", {95'd0, last}, 96'd0);
    step(); step();
    chk("wide_idx", {64'd0, ndindex_0}, 96'd2);
    chk("wide_last2", {95'd0, last}, 96'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    ext_0 = 4; ext_1 = 4; ext_2 = 4; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("prerst_tuple", {ndindex_2, ndindex_1, ndindex_0}, tup(1, 1, 0));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; out_ready = 1'b0;
    chk("mrst_valid", {95'd0, out_valid}, 96'd0);
    chk("mrst_busy", {95'd0, busy}, 96'd0);
    chk("mrst_done", {95'd0, done}, 96'd0);
    chk("mrst_last", {95'd0, last}, 96'd0);
    chk("mrst_tuple", {ndindex_2, ndindex_1, ndindex_0}, 96'd0);
`ifdef NDSCHED_LINEAR_EN
    chk("mrst_lin", {64'd0, lin_index}, 96'd0);
`endif
    step();
    chk("mrst_done2", {95'd0, done}, 96'd0);
    chk("mrst_valid2", {95'd0, out_valid}, 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
